// File: rtl/filt_out_pkg.sv
// Shared constants for the filter output stage: mode encodings, default
// coordinate width, split marker colour and a blanking helper.
package filt_out_pkg;

  localparam int          COORD_W_DEF   = 11;
  localparam logic [1:0]  MODE_RAW      = 2'b00;
  localparam logic [1:0]  MODE_FLT      = 2'b01;
  localparam logic [1:0]  MODE_SPLIT    = 2'b10;
  localparam logic [1:0]  MODE_SPLIT_SW = 2'b11;
  localparam logic [23:0] MARKER_RGB    = 24'hFFFFFF;

  // Forces pixel data to black outside the active window.
  function automatic logic [23:0] blank_rgb(input logic dv, input logic [23:0] rgb);
    return dv ? rgb : 24'h000000;
  endfunction

endpackage

// File: rtl/video_delay.sv
// Fixed-depth shift register used to align the raw video path with the
// filter output; synchronous active-high reset clears every stage.
module video_delay #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  // Shift one stage per clock; stage DEPTH-1 is DEPTH cycles behind i_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= {WIDTH{1'b0}};
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/filt_out_mux.sv
// Output stage after the convolution filter: aligns raw video, tracks col/row
// and selects raw/filtered/split output. Optional macro SPLIT_BORDER_EN adds a white marker column.
module filt_out_mux #(
  parameter int DELAY   = 26,
  parameter int COORD_W = filt_out_pkg::COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         raw_red,
  input  logic [7:0]         raw_green,
  input  logic [7:0]         raw_blue,
  input  logic               raw_dv,
  input  logic               raw_hs,
  input  logic               raw_vs,
  input  logic [7:0]         flt_red,
  input  logic [7:0]         flt_green,
  input  logic [7:0]         flt_blue,
  input  logic               flt_dv,
  input  logic               flt_hs,
  input  logic               flt_vs,
  input  logic [1:0]         mode,
  input  logic [COORD_W-1:0] split_x,
  output logic [7:0]         out_red,
  output logic [7:0]         out_green,
  output logic [7:0]         out_blue,
  output logic               out_dv,
  output logic               out_hs,
  output logic               out_vs,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               align_err
);
  import filt_out_pkg::*;

  localparam logic [COORD_W-1:0] X_MAX  = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] X_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] X_ONE  = {{(COORD_W-1){1'b0}}, 1'b1};

  logic [26:0]        w_raw_in;
  logic [26:0]        w_raw_dly;
  logic               w_dly_dv;
  logic [23:0]        w_dly_rgb;
  logic               w_unused_sync;
  logic               w_vs_rise;
  logic               w_dv_fall;
  logic [COORD_W-1:0] w_cnt_x;
  logic               w_left;
  logic [23:0]        w_pix;

  logic [COORD_W-1:0] r_cnt_x;
  logic [COORD_W-1:0] r_cnt_y;
  logic [1:0]         r_mode;
  logic [23:0]        r_out_rgb;
  logic               r_out_dv;
  logic               r_out_hs;
  logic               r_out_vs;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic               r_align_err;

  assign w_raw_in = {raw_dv, raw_hs, raw_vs, blank_rgb(raw_dv, {raw_red, raw_green, raw_blue})};

  video_delay #(.WIDTH(27), .DEPTH(DELAY)) u_raw_delay (
    .clk    (clk),
    .rst    (rst),
    .i_data (w_raw_in),
    .o_data (w_raw_dly)
  );

  // Delayed raw sync is carried for alignment only; the output timing comes from the filter.
  assign w_dly_dv      = w_raw_dly[26];
  assign w_unused_sync = ^w_raw_dly[25:24];
  assign w_dly_rgb     = w_raw_dly[23:0];

  // The registered output timing doubles as the previous-cycle flt_dv/flt_vs.
  assign w_vs_rise = flt_vs & ~r_out_vs;
  assign w_dv_fall = ~flt_dv & r_out_dv;
  assign w_cnt_x   = flt_dv ? r_cnt_x : X_ZERO;
  assign w_left    = (w_cnt_x < split_x);

  // Per-pixel source selection on the latched frame mode.
  always_comb begin
    w_pix = 24'h000000;
    if (flt_dv) begin
      case (r_mode)
        MODE_RAW:      w_pix = w_dly_rgb;
        MODE_FLT:      w_pix = {flt_red, flt_green, flt_blue};
        MODE_SPLIT:    w_pix = w_left ? w_dly_rgb : {flt_red, flt_green, flt_blue};
        MODE_SPLIT_SW: w_pix = w_left ? {flt_red, flt_green, flt_blue} : w_dly_rgb;
        default:       w_pix = {flt_red, flt_green, flt_blue};
      endcase
`ifdef SPLIT_BORDER_EN
      if (r_mode[1] && (w_cnt_x == split_x)) begin
        w_pix = MARKER_RGB;
      end else begin
        w_pix = w_pix;
      end
`endif
    end else begin
      w_pix = 24'h000000;
    end
  end

  // Counters, frame-mode latch, sticky alignment flag and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_x     <= X_ZERO;
      r_cnt_y     <= X_ZERO;
      r_mode      <= MODE_FLT;
      r_out_rgb   <= 24'h000000;
      r_out_dv    <= 1'b0;
      r_out_hs    <= 1'b0;
      r_out_vs    <= 1'b0;
      r_col       <= X_ZERO;
      r_row       <= X_ZERO;
      r_align_err <= 1'b0;
    end else begin
      r_out_rgb   <= w_pix;
      r_out_dv    <= flt_dv;
      r_out_hs    <= flt_hs;
      r_out_vs    <= flt_vs;
      r_col       <= w_cnt_x;
      r_row       <= r_cnt_y;
      r_align_err <= r_align_err | (w_dly_dv != flt_dv);
      if (!flt_dv) begin
        r_cnt_x <= X_ZERO;
      end else if (r_cnt_x != X_MAX) begin
        r_cnt_x <= r_cnt_x + X_ONE;
      end else begin
        r_cnt_x <= r_cnt_x;
      end
      // A frame start beats an end-of-line in the same cycle.
      if (w_vs_rise) begin
        r_cnt_y <= X_ZERO;
      end else if (w_dv_fall && (r_cnt_y != X_MAX)) begin
        r_cnt_y <= r_cnt_y + X_ONE;
      end else begin
        r_cnt_y <= r_cnt_y;
      end
      if (w_vs_rise) begin
        r_mode <= mode;
      end else begin
        r_mode <= r_mode;
      end
    end
  end

  assign out_red   = r_out_rgb[23:16];
  assign out_green = r_out_rgb[15:8];
  assign out_blue  = r_out_rgb[7:0];
  assign out_dv    = r_out_dv;
  assign out_hs    = r_out_hs;
  assign out_vs    = r_out_vs;
  assign col       = r_col;
  assign row       = r_row;
  assign align_err = r_align_err;

endmodule
